// File: rtl/regfile_pkg.sv
// Shared types and defaults for the decode-stage register file.
//   clear_state_t : soft-clear engine states
//   DEF_DATA_W    : default register width
//   DEF_ADDR_W    : default register address width
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEARING = 2'd1,
    DONE     = 2'd2
  } clear_state_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: writeback, two read ports, issue
// tracking and soft-clear handshake.
//   master : the pipeline driving addresses/strobes, sampling data/busy
//   slave  : the register file
interface register_file_sb_if #(
  parameter int unsigned DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::DEF_ADDR_W
);

  logic              writeEnable;
  logic [ADDR_W-1:0] writeAdd;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readAdd1;
  logic [ADDR_W-1:0] readAdd2;
  logic [DATA_W-1:0] readOut1;
  logic [DATA_W-1:0] readOut2;
  logic              issueEnable;
  logic [ADDR_W-1:0] issueAdd;
  logic              busy1;
  logic              busy2;
  logic              clearReq;
  logic              clearBusy;
  logic              clearDone;

  modport master (
    output writeEnable, writeAdd, writeData,
    output readAdd1, readAdd2,
    output issueEnable, issueAdd,
    output clearReq,
    input  readOut1, readOut2,
    input  busy1, busy2,
    input  clearBusy, clearDone
  );

  modport slave (
    input  writeEnable, writeAdd, writeData,
    input  readAdd1, readAdd2,
    input  issueEnable, issueAdd,
    input  clearReq,
    output readOut1, readOut2,
    output busy1, busy2,
    output clearBusy, clearDone
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, wiped by the soft-clear start.
//   clk, reset            : clock, async active-high reset
//   clear_all             : drop every pending bit (and any same-edge issue)
//   issue_en / issue_addr : destination register of a newly issued instruction
//   wb_en / wb_addr       : valid writeback
//   rd_addr1 / rd_addr2   : read port addresses to look up
//   fwd1 / fwd2           : read port is being forwarded this cycle
//   busy1 / busy2         : read port has a pending, unforwarded write
module reg_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_all,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              fwd1,
  input  logic              fwd2,
  output logic              busy1,
  output logic              busy2
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                issue_ok;

  // The hardwired zero register never has a producer in flight.
  assign issue_ok = issue_en && !(ZERO_REG && (issue_addr == '0));

  // Set is applied after clear so a same-address issue+writeback stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) begin
      pending_nxt[wb_addr] = 1'b0;
    end
    if (issue_ok) begin
      pending_nxt[issue_addr] = 1'b1;
    end
    if (clear_all) begin
      pending_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign busy1 = pending[rd_addr1] && !fwd1;
  assign busy2 = pending[rd_addr2] && !fwd2;

endmodule

// File: rtl/register_file_sb.sv
// Decode-stage register file: two combinational read ports, one synchronous
// write port, optional write-to-read bypass, optional hardwired r0, pending
// write scoreboard and a sequential soft-clear engine.
//   clk   : clock, all state updates on the rising edge
//   reset : async active-high reset
//   rf    : register_file_sb_if slave (write/read/issue/clear signals)
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  register_file_sb_if.slave  rf
);

  localparam int unsigned       NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clear_state_t      state;
  logic [ADDR_W-1:0] idx;
  logic              clear_busy_q;
  logic              clear_done_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wv;
  logic              issue_v;
  logic              clear_start;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              sb_busy1;
  logic              sb_busy2;

  // Qualified write/issue: both are dropped while the clear engine owns the array.
  assign wv          = rf.writeEnable && !clear_busy_q &&
                       !(ZERO_REG && (rf.writeAdd == '0));
  assign issue_v     = rf.issueEnable && !clear_busy_q;
  assign clear_start = (state == IDLE) && rf.clearReq;

  assign fwd1 = BYPASS && wv && (rf.writeAdd == rf.readAdd1);
  assign fwd2 = BYPASS && wv && (rf.writeAdd == rf.readAdd2);

  // Soft-clear sequencer; clearBusy/clearDone are registered alongside state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done_q <= 1'b0;
          if (rf.clearReq) begin
            state        <= CLEARING;
            idx          <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        CLEARING: begin
          idx <= idx + ADDR_W'(1);
          if (idx == LAST_IDX) begin
            state        <= DONE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          clear_done_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          clear_busy_q <= 1'b0;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Register array: the clear engine has priority over writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clear_busy_q) begin
      regs[idx] <= '0;
    end else if (wv) begin
      regs[rf.writeAdd] <= rf.writeData;
    end
  end

  // Read muxes: zero register beats bypass beats array.
  always_comb begin
    rd1 = regs[rf.readAdd1];
    if (fwd1) begin
      rd1 = rf.writeData;
    end
    if (ZERO_REG && (rf.readAdd1 == '0)) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = regs[rf.readAdd2];
    if (fwd2) begin
      rd2 = rf.writeData;
    end
    if (ZERO_REG && (rf.readAdd2 == '0)) begin
      rd2 = '0;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .clear_all  (clear_start),
    .issue_en   (issue_v),
    .issue_addr (rf.issueAdd),
    .wb_en      (wv),
    .wb_addr    (rf.writeAdd),
    .rd_addr1   (rf.readAdd1),
    .rd_addr2   (rf.readAdd2),
    .fwd1       (fwd1),
    .fwd2       (fwd2),
    .busy1      (sb_busy1),
    .busy2      (sb_busy2)
  );

  assign rf.readOut1  = rd1;
  assign rf.readOut2  = rd2;
  assign rf.busy1     = sb_busy1;
  assign rf.busy2     = sb_busy2;
  assign rf.clearBusy = clear_busy_q;
  assign rf.clearDone = clear_done_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1,
// BYPASS=1): directed scenarios followed by random traffic, all compared
// against a behavioural model of the register file.
module tb_register_file_sb;

  logic clk;
  logic reset;

  int n_assert;
  int n_fail;

  // Behavioural model state.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_clearing;
  bit          m_done;
  int          m_left;
  int          m_pos;

  register_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  register_file_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.writeEnable = 1'b0;
    bus.writeAdd    = '0;
    bus.writeData   = '0;
    bus.readAdd1    = '0;
    bus.readAdd2    = '0;
    bus.issueEnable = 1'b0;
    bus.issueAdd    = '0;
    bus.clearReq    = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_clearing = 1'b0;
    m_done     = 1'b0;
    m_left     = 0;
    m_pos      = 0;
  endtask

  function automatic bit model_wv();
    return bus.writeEnable && !m_clearing && (int'(bus.writeAdd) != 0);
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return 32'h0;
    if (model_wv() && int'(bus.writeAdd) == a) return bus.writeData;
    return m_regs[a];
  endfunction

  function automatic bit model_busy(input int a);
    return m_pend[a] && !(model_wv() && int'(bus.writeAdd) == a);
  endfunction

  // One clock: compare all outputs mid-cycle, then advance the model.
  task automatic step();
    bit wvm;
    int wa, ia;
    @(negedge clk);
    check("readOut1",  bus.readOut1,  model_read(int'(bus.readAdd1)));
    check("readOut2",  bus.readOut2,  model_read(int'(bus.readAdd2)));
    check("busy1",     32'(bus.busy1), 32'(model_busy(int'(bus.readAdd1))));
    check("busy2",     32'(bus.busy2), 32'(model_busy(int'(bus.readAdd2))));
    check("clearBusy", 32'(bus.clearBusy), 32'(m_clearing));
    check("clearDone", 32'(bus.clearDone), 32'(m_done));
    wvm = model_wv();
    wa  = int'(bus.writeAdd);
    ia  = int'(bus.issueAdd);
    if (m_clearing) begin
      m_regs[m_pos] = '0;
      m_pos++;
      m_left--;
      if (m_left == 0) begin
        m_clearing = 1'b0;
        m_done     = 1'b1;
      end
    end else begin
      if (wvm) begin
        m_regs[wa] = bus.writeData;
        m_pend[wa] = 1'b0;
      end
      if (bus.issueEnable && ia != 0) m_pend[ia] = 1'b1;
      if (bus.clearReq && !m_done) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_clearing = 1'b1;
        m_left     = 32;
        m_pos      = 0;
      end
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    n_assert = 0;
    n_fail   = 0;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #2;
    check("rst_readOut1", bus.readOut1, 32'h0);
    check("rst_busy1", 32'(bus.busy1), 32'h0);
    check("rst_clearBusy", 32'(bus.clearBusy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Write r10 with same-cycle bypass, then read it back from the array.
    bus.writeEnable = 1'b1; bus.writeAdd = 5'd10; bus.writeData = 32'hAA;
    bus.readAdd1 = 5'd10;
    #1;
    check("r10_bypass", bus.readOut1, 32'hAA);
    step();
    bus.writeEnable = 1'b0;
    #1;
    check("r10_next", bus.readOut1, 32'hAA);
    step();

    // r0 is hardwired: write and issue are both ignored.
    bus.writeEnable = 1'b1; bus.writeAdd = 5'd0; bus.writeData = 32'hFFFF_FFFF;
    bus.issueEnable = 1'b1; bus.issueAdd = 5'd0; bus.readAdd1 = 5'd0;
    step();
    idle_inputs();
    #1;
    check("r0_read", bus.readOut1, 32'h0);
    check("r0_busy", 32'(bus.busy1), 32'h0);
    step();

    // Issue r17, then writeback with bypass clears busy in the same cycle.
    bus.issueEnable = 1'b1; bus.issueAdd = 5'd17; bus.readAdd2 = 5'd17;
    step();
    bus.issueEnable = 1'b0;
    #1;
    check("r17_busy", 32'(bus.busy2), 32'h1);
    step();
    bus.writeEnable = 1'b1; bus.writeAdd = 5'd17; bus.writeData = 32'hA;
    #1;
    check("r17_wb_busy", 32'(bus.busy2), 32'h0);
    check("r17_wb_data", bus.readOut2, 32'hA);
    step();
    bus.writeEnable = 1'b0;
    #1;
    check("r17_after", 32'(bus.busy2), 32'h0);
    step();

    // Same-edge issue and writeback to r5: the issue wins.
    bus.issueEnable = 1'b1; bus.issueAdd = 5'd5;
    bus.writeEnable = 1'b1; bus.writeAdd = 5'd5; bus.writeData = 32'h55;
    step();
    idle_inputs();
    bus.readAdd1 = 5'd5;
    #1;
    check("r5_set_wins", 32'(bus.busy1), 32'h1);
    step();

    // Fill r1..r31, keep a few pending, then soft clear.
    for (int i = 1; i < 32; i++) begin
      bus.writeEnable = 1'b1; bus.writeAdd = 5'(i); bus.writeData = 32'h100 + 32'(i);
      bus.issueEnable = 1'b1; bus.issueAdd = 5'(31 - i);
      bus.readAdd1 = 5'(i); bus.readAdd2 = 5'(i - 1);
      step();
    end
    idle_inputs();
    bus.clearReq = 1'b1;
    step();
    bus.clearReq = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.writeEnable = (i == 5);
      bus.writeAdd = 5'd3; bus.writeData = 32'h1234;
      bus.issueEnable = (i == 6); bus.issueAdd = 5'd9;
      bus.readAdd1 = 5'(i); bus.readAdd2 = 5'd3;
      bus.clearReq = (i == 10);
      if (bus.clearBusy) busy_cnt++;
      if (bus.clearDone) done_cnt++;
      step();
    end
    idle_inputs();
    check("clear_len", 32'(busy_cnt), 32'd32);
    check("clear_done_cnt", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus.readAdd1 = 5'(2 * i); bus.readAdd2 = 5'(2 * i + 1);
      #1;
      check("cleared_rd1", bus.readOut1, 32'h0);
      check("cleared_rd2", bus.readOut2, 32'h0);
      check("cleared_busy", {30'h0, bus.busy1, bus.busy2}, 32'h0);
      step();
    end

    // Reset ten cycles into a clear, then run a clean clear.
    for (int i = 1; i < 8; i++) begin
      bus.writeEnable = 1'b1; bus.writeAdd = 5'(i); bus.writeData = 32'hBEEF0000 + 32'(i);
      bus.issueEnable = 1'b1; bus.issueAdd = 5'(i + 10);
      step();
    end
    idle_inputs();
    bus.clearReq = 1'b1;
    step();
    bus.clearReq = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    bus.readAdd1 = 5'd20; bus.readAdd2 = 5'd12;
    #1;
    model_reset();
    check("midrst_clearBusy", 32'(bus.clearBusy), 32'h0);
    check("midrst_clearDone", 32'(bus.clearDone), 32'h0);
    check("midrst_rd1", bus.readOut1, 32'h0);
    check("midrst_busy2", 32'(bus.busy2), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.readAdd1 = 5'(i); bus.readAdd2 = 5'(31 - i);
      step();
    end
    bus.clearReq = 1'b1;
    step();
    bus.clearReq = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      if (bus.clearDone) done_cnt++;
      step();
    end
    check("reclear_done_cnt", 32'(done_cnt), 32'd1);

    // Random traffic, biased toward a few addresses to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      bus.writeEnable = 1'($urandom_range(0, 1));
      bus.writeAdd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.writeData   = $urandom;
      bus.issueEnable = 1'($urandom_range(0, 1));
      bus.issueAdd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.readAdd1    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.readAdd2    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.clearReq    = ($urandom_range(0, 99) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the single-issue MIPS register file. Width and depth are configurable.
- Keeps two combinational read ports and one synchronous write port.
- Adds optional write-to-read bypass, an optional hardwired zero register, and a per-register pending-write scoreboard for the pipelined datapath.
- Adds a sequential soft-clear engine that zeroes the array without asserting reset.
- Sits in the decode stage. Hazard logic consumes the busy outputs.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width. NUM_REGS = 2**ADDR_W is a derived localparam.
- ZERO_REG, 1, when 1: register 0 always reads 0, writes to it are ignored, and it is never pending.
- BYPASS, 1, when 1: a write in the current cycle is forwarded to a matching read port in the same cycle.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- writeEnable  input  1  writeback strobe
- writeAdd  input  ADDR_W  writeback register address
- writeData  input  DATA_W  writeback data
- readAdd1  input  ADDR_W  read port 1 address
- readAdd2  input  ADDR_W  read port 2 address
- readOut1  output  DATA_W  read port 1 data, combinational
- readOut2  output  DATA_W  read port 2 data, combinational
- issueEnable  input  1  an instruction targeting issueAdd has issued
- issueAdd  input  ADDR_W  destination register of the issued instruction
- busy1  output  1  readAdd1 has a pending, unforwarded write
- busy2  output  1  readAdd2 has a pending, unforwarded write
- clearReq  input  1  request soft clear
- clearBusy  output  1  soft clear in progress
- clearDone  output  1  one-cycle pulse when soft clear completes

Behaviour:
- Reset (asynchronous, active-high): all registers 0, all pending bits 0, FSM to IDLE, clearBusy 0, clearDone 0. As a result readOut1/2 = 0 and busy1/2 = 0.
- Write valid (wv): writeEnable & !clearBusy & !(ZERO_REG & writeAdd==0). On the rising edge with wv, reg[writeAdd] <= writeData. Read-after-write latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Read, per port N:
  - If ZERO_REG and readAddN==0: output 0.
  - Else if BYPASS and wv and writeAdd==readAddN: output writeData.
  - Else: output reg[readAddN].
- Scoreboard: pending[NUM_REGS] bit vector.
  - Issue valid: issueEnable & !clearBusy & !(ZERO_REG & issueAdd==0). On the edge, it sets pending[issueAdd].
  - wv clears pending[writeAdd] on the edge.
  - Same address issued and written back on the same edge: the set wins (a new producer is in flight).
  - Issue and writeback to different addresses on the same edge: both take effect.
- busyN = pending[readAddN] & !(BYPASS & wv & writeAdd==readAddN). With BYPASS=0, busyN = pending[readAddN].
- Soft-clear FSM. States: IDLE, CLEARING, DONE. A counter idx of ADDR_W bits steps through the array.
  - IDLE -> CLEARING on an edge where clearReq=1. That edge resets idx to 0 and clears all pending bits. An issue on the same edge is dropped; a write on the same edge is performed and later overwritten.
  - CLEARING: clearBusy=1. Each edge writes reg[idx] <= 0 and increments idx. The edge that writes idx==NUM_REGS-1 moves to DONE, so clearBusy is high for exactly NUM_REGS cycles.
  - DONE: clearBusy=0, clearDone=1 for one cycle, then IDLE unconditionally.
  - clearReq is ignored in CLEARING and DONE. No request is queued.
  - During CLEARING, writes and issues are dropped (wv=0, no bypass), and reads return the partially cleared array.
  - idx wraps naturally at NUM_REGS-1. No out-of-range access.
- Reset mid-clear: immediate return to IDLE with the array zeroed. No clearDone pulse.

Decomposition:
- Package regfile_pkg contains:
  - the clear FSM state enum (IDLE, CLEARING, DONE);
  - default DATA_W and ADDR_W constants.
- One sub-module, reg_scoreboard, holds the pending vector, set/clear priority and busy lookup. It has parameters ADDR_W and ZERO_REG; its clear input is driven by the FSM.

Test Plan:
- Write 32'hAA to r10, then read r10 on port 1 the next cycle -> readOut1 = 32'hAA. With BYPASS=1, reading r10 in the same cycle as the write also gives 32'hAA.
- ZERO_REG=1: write 32'hFFFF_FFFF to r0 -> readOut1 = 0 on the following cycle. Issue to r0 -> busy stays 0.
- Issue r17, then readAdd2=17 -> busy2=1 from the next cycle. Writeback r17 with 32'hA -> busy2=0 and readOut2=32'hA in that same cycle (BYPASS=1), and busy2 stays 0 afterwards.
- Issue r5 and writeback r5 on the same edge -> pending[5]=1 afterwards, so busy1=1 for readAdd1=5.
- Fill r1..r31 with nonzero values, pulse clearReq -> clearBusy high for exactly 32 cycles, then clearDone for 1 cycle. All reads return 0, all busy bits are 0, and a write attempted mid-clear is dropped.
- Assert reset 10 cycles into a clear -> clearBusy=0 immediately, no clearDone, all registers 0. A subsequent clearReq completes normally.
